// File: rtl/binary_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_converter
//
// Sequential double-dabble (shift-add-3) converter from an unsigned binary
// operand to packed BCD digits. It feeds the per-digit BCD-to-7-segment
// decoders: digit k of bcd_out drives decoder k.
// One conversion runs per accepted start pulse and takes BIN_W clock cycles.
// The previous result stays on bcd_out until the next conversion completes.
//
// Parameters
//   BIN_W   width of the binary operand; one shift step per bit
//   DIGITS  number of BCD digits produced; digit 0 is bcd_out[3:0] (LSD)
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   start     in   conversion request, sampled only while idle (busy=0)
//   bin_in    in   binary operand, captured on the accepting edge only
//   busy      out  conversion in progress
//   done      out  one-cycle pulse: bcd_out/overflow were just updated
//   bcd_out   out  packed BCD result, digit k = bcd_out[4k+3:4k]
//   overflow  out  operand exceeded 10^DIGITS-1; bcd_out holds value mod 10^DIGITS
//
// Configuration macro
//   BCD_LEADING_BLANK_EN  when defined, leading-zero digits above the most
//                         significant non-zero digit are driven as 4'hF so the
//                         downstream decoders blank them. Digit 0 is never
//                         blanked. The reset value of bcd_out follows the same
//                         rule (digit 0 = 0, all others = F).
// -----------------------------------------------------------------------------
module binary_to_bcd_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

`ifdef BCD_LEADING_BLANK_EN
    // Every digit blank except digit 0, which shows a zero.
    localparam logic [BCD_W-1:0] BCD_RESET = ~(BCD_W'(4'hF));
`else
    localparam logic [BCD_W-1:0] BCD_RESET = '0;
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [BIN_W-1:0]   operand_reg, operand_next;
    logic [BCD_W-1:0]   scratch_reg, scratch_next;
    logic               sticky_reg, sticky_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic               ovf_reg, ovf_next;
    logic               done_reg, done_next;

    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   stepped;
    logic [BCD_W-1:0]   formatted;
    logic               carry_out;

    // Add-3 correction: any digit >= 5 would become >= 10 after the shift,
    // so pre-adding 3 makes the shift carry correctly into the next digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            assign adjusted[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                       ? scratch_reg[4*gi +: 4] + 4'd3
                                       : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // A one leaving the top digit means the value needs more digits than
    // DIGITS; the remaining scratch is then the value modulo 10^DIGITS.
    assign carry_out = adjusted[BCD_W-1];
    assign stepped   = {adjusted[BCD_W-2:0], operand_reg[BIN_W-1]};

`ifdef BCD_LEADING_BLANK_EN
    // zero_from[k]: digits k..DIGITS-1 of the final scratch are all zero.
    logic [DIGITS:1] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    assign formatted[3:0]    = stepped[3:0];
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign zero_from[gi] = (stepped[4*gi +: 4] == 4'h0) & zero_from[gi+1];
            assign formatted[4*gi +: 4] = zero_from[gi] ? 4'hF : stepped[4*gi +: 4];
        end
    endgenerate
`else
    assign formatted = stepped;
`endif

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        operand_next = operand_reg;
        scratch_next = scratch_reg;
        sticky_next  = sticky_reg;
        bcd_next     = bcd_reg;
        ovf_next     = ovf_reg;
        done_next    = 1'b0;
        busy         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SHIFT;
                    operand_next = bin_in;
                    scratch_next = '0;
                    sticky_next  = 1'b0;
                    count_next   = '0;
                end
            end
            SHIFT: begin
                busy         = 1'b1;
                operand_next = operand_reg << 1;
                scratch_next = stepped;
                sticky_next  = sticky_reg | carry_out;
                count_next   = count_reg + 1'b1;
                if (count_reg == LAST_STEP) begin
                    // Final step: publish the result in the same edge.
                    state_next = IDLE;
                    count_next = '0;
                    bcd_next   = formatted;
                    ovf_next   = sticky_reg | carry_out;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            operand_reg <= '0;
            scratch_reg <= '0;
            sticky_reg  <= 1'b0;
            bcd_reg     <= BCD_RESET;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            operand_reg <= operand_next;
            scratch_reg <= scratch_next;
            sticky_reg  <= sticky_next;
            bcd_reg     <= bcd_next;
            ovf_reg     <= ovf_next;
            done_reg    <= done_next;
        end
    end

    assign done     = done_reg;
    assign bcd_out  = bcd_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd_converter
//
// Bench for binary_to_bcd_converter. Two instances share the same stimulus:
// dut3 (DIGITS=3) and dut2 (DIGITS=2, for the overflow cases). A cycle-level
// behavioural model derives busy/done timing from a countdown and the result
// from decimal arithmetic; a compare process checks every cycle out of reset.
// Directed conversions add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd_converter;

    localparam int BIN_W = 8;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [11:0] RST3 = 12'hFF0;
    localparam logic [7:0]  RST2 = 8'hF0;
`else
    localparam logic [11:0] RST3 = 12'h000;
    localparam logic [7:0]  RST2 = 8'h00;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy3, done3, ovf3;
    logic [11:0]      bcd3;
    logic             busy2, done2, ovf2;
    logic [7:0]       bcd2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    binary_to_bcd_converter #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
        .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
    );

    binary_to_bcd_converter #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of val (mod 10^nd), with optional leading blanking.
    function automatic logic [31:0] ref_bcd(input int val, input int nd);
        logic [31:0] r;
        int p;
        bit lead;
        r = '0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'((val / p) % 10);
            p = p * 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        lead = 1'b1;
        for (int k = nd - 1; k >= 1; k--) begin
            if (lead && r[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    bit          m_busy, m_done, m_ovf3, m_ovf2;
    int          m_left, m_val;
    logic [11:0] m_bcd3;
    logic [7:0]  m_bcd2;
    logic [31:0] tmp3, tmp2;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_bcd3  = RST3;
            m_bcd2  = RST2;
            m_ovf3  = 1'b0;
            m_ovf2  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    tmp3   = ref_bcd(m_val, 3);
                    tmp2   = ref_bcd(m_val, 2);
                    m_bcd3 = tmp3[11:0];
                    m_bcd2 = tmp2[7:0];
                    m_ovf3 = (m_val > 999);
                    m_ovf2 = (m_val > 99);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = BIN_W;
                m_val  = int'(bin_in);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (!reset && m_valid) begin
            check("busy3", 32'(busy3), 32'(m_busy));
            check("done3", 32'(done3), 32'(m_done));
            check("bcd3", 32'(bcd3), 32'(m_bcd3));
            check("ovf3", 32'(ovf3), 32'(m_ovf3));
            check("busy2", 32'(busy2), 32'(m_busy));
            check("done2", 32'(done2), 32'(m_done));
            check("bcd2", 32'(bcd2), 32'(m_bcd2));
            check("ovf2", 32'(ovf2), 32'(m_ovf2));
        end
    end

    // Called at a negedge. Asserts start with v; waits (bounded) for done.
    // hold=1 keeps start high and switches bin_in to 99 while busy.
    task automatic do_conv(input int v, input bit hold);
        int lat;
        bin_in = BIN_W'(v);
        start  = 1'b1;
        lat    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (hold) bin_in = 8'd99;
                else      start  = 1'b0;
            end
            if (done3) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd9);
        $display("conv in=%0d bcd3=%h ovf3=%0d bcd2=%h ovf2=%0d latency=%0d",
                 v, bcd3, ovf3, bcd2, ovf2, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_bcd3", 32'(bcd3), 32'(RST3));
        check("rst_ovf", 32'(ovf3), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Maximum operand
        do_conv(255, 1'b0);
        check("t1_bcd", 32'(bcd3), 32'h255);
        check("t1_ovf", 32'(ovf3), 32'd0);
        check("t1_busy", 32'(busy3), 32'd0);

        // Zero and single digit
        do_conv(0, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
        check("t2_zero", 32'(bcd3), 32'hFF0);
`else
        check("t2_zero", 32'(bcd3), 32'h000);
`endif
        do_conv(7, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
        check("t2_seven", 32'(bcd3), 32'hFF7);
`else
        check("t2_seven", 32'(bcd3), 32'h007);
`endif

        // start held while busy is ignored; start in the done cycle is taken
        do_conv(42, 1'b1);
`ifdef BCD_LEADING_BLANK_EN
        check("t3_first", 32'(bcd3), 32'hF42);
`else
        check("t3_first", 32'(bcd3), 32'h042);
`endif
        do_conv(99, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
        check("t3_second", 32'(bcd3), 32'hF99);
`else
        check("t3_second", 32'(bcd3), 32'h099);
`endif

        // Reset in mid-conversion
        bin_in = 8'd200;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("t4_busy", 32'(busy3), 32'd0);
        check("t4_done", 32'(done3), 32'd0);
        check("t4_bcd3", 32'(bcd3), 32'(RST3));
        check("t4_bcd2", 32'(bcd2), 32'(RST2));
        check("t4_ovf", 32'(ovf3), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("t4_no_done", 32'(bcd3), 32'(RST3));
        do_conv(13, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
        check("t4_after", 32'(bcd3), 32'hF13);
`else
        check("t4_after", 32'(bcd3), 32'h013);
`endif

        // Two-digit instance overflow boundary
        do_conv(100, 1'b0);
        check("t5_ovf_100", 32'(ovf2), 32'd1);
`ifdef BCD_LEADING_BLANK_EN
        check("t5_bcd_100", 32'(bcd2), 32'hF0);
        check("t5_bcd3_100", 32'(bcd3), 32'h100);
`else
        check("t5_bcd_100", 32'(bcd2), 32'h00);
        check("t5_bcd3_100", 32'(bcd3), 32'h100);
`endif
        do_conv(99, 1'b0);
        check("t5_ovf_99", 32'(ovf2), 32'd0);
        check("t5_bcd_99", 32'(bcd2), 32'h99);

        // Every operand value
        for (int v = 0; v < 256; v++) begin
            do_conv(v, 1'b0);
            tmp3 = ref_bcd(v, 3);
            check("t6_bcd3", 32'(bcd3), 32'(tmp3[11:0]));
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
